// File: rtl/awg_frame_loader_if.sv
// awg_frame_loader_if: bundles the rx-queue pop port, the AWG sample-write bus
// and the frame status strobes of the AWG frame loader.
//   master : the frame loader (pops bytes, drives writes and status)
//   slave  : the environment (rx byte queue, AWG memories, status observer)
interface awg_frame_loader_if #(
  parameter int NBITS = 12
);
  logic [7:0]       in_byte;
  logic             em;
  logic             pp;
  logic [NBITS-1:0] awg_in;
  logic [7:0]       awg_addr;
  logic             awg_sel;
  logic             awg_ld;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  in_byte, em,
    output pp, awg_in, awg_addr, awg_sel, awg_ld, busy, done, err
  );

  modport slave (
    output in_byte, em,
    input  pp, awg_in, awg_addr, awg_sel, awg_ld, busy, done, err
  );
endinterface

// File: rtl/awg_frame_loader.sv
// awg_frame_loader: parses host frames (A5 CTRL START COUNT {HI LO}xN [CHK])
// popped from the rx byte queue and turns each sample into a one-cycle write
// strobe for the AWG waveform memories.
// Optional feature macro: AWG_LOADER_CHECKSUM_EN
//   defined   : a trailing CHK byte is compared with the modulo-256 byte sum;
//               done on match, err on mismatch.
//   undefined : the frame ends after the last LO byte, done follows the last
//               write strobe by one cycle, err comes only from the timeout.
module awg_frame_loader #(
  parameter int NBITS   = 12,
  parameter int TIMEOUT = 100000
) (
  input  logic               clk,
  input  logic               rst,
  awg_frame_loader_if.master bus
);

`ifdef AWG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, CTRL, START, COUNT, SHI, SLO, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, CTRL, START, COUNT, SHI, SLO} state_t;
`endif

  localparam int             TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       hi_q, hi_d;
  logic [8:0]       remain_q, remain_d;
  logic             sel_q, sel_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [NBITS-1:0] awg_in_q, awg_in_d;
  logic [7:0]       awg_addr_q, awg_addr_d;
  logic             awg_sel_q, awg_sel_d;
  logic             awg_ld_q, awg_ld_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef AWG_LOADER_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
`else
  logic             fin_q, fin_d;
`endif

  logic pop;

  // A byte is consumed whenever the queue has one and reset is not asserted.
  assign bus.pp = !bus.em && !rst;
  assign pop    = bus.pp;

  assign bus.awg_in   = awg_in_q;
  assign bus.awg_addr = awg_addr_q;
  assign bus.awg_sel  = awg_sel_q;
  assign bus.awg_ld   = awg_ld_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != IDLE);

  // Next-state logic: frame parsing, address/count bookkeeping and timeout abort.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    remain_d   = remain_q;
    sel_d      = sel_q;
    awg_in_d   = awg_in_q;
    awg_addr_d = awg_addr_q;
    awg_sel_d  = awg_sel_q;
    awg_ld_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef AWG_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`else
    fin_d      = 1'b0;
    done_d     = fin_q;
`endif

    if (state_q == IDLE || pop) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    if (state_q != IDLE && !pop && timer_q == TLAST) begin
      err_d   = 1'b1;
      state_d = IDLE;
      timer_d = '0;
    end else if (pop) begin
      case (state_q)
        IDLE: begin
          if (bus.in_byte == 8'hA5) begin
            state_d = CTRL;
`ifdef AWG_LOADER_CHECKSUM_EN
            sum_d   = 8'h00;
`endif
          end
        end
        CTRL: begin
          sel_d   = bus.in_byte[0];
          state_d = START;
        end
        START: begin
          addr_d  = bus.in_byte;
          state_d = COUNT;
        end
        COUNT: begin
          remain_d = (bus.in_byte == 8'h00) ? 9'd256 : {1'b0, bus.in_byte};
          state_d  = SHI;
        end
        SHI: begin
          hi_d    = bus.in_byte;
          state_d = SLO;
        end
        SLO: begin
          awg_ld_d   = 1'b1;
          awg_addr_d = addr_q;
          awg_in_d   = NBITS'({hi_q, bus.in_byte});
          awg_sel_d  = sel_q;
          addr_d     = addr_q + 8'd1;
          remain_d   = remain_q - 9'd1;
          if (remain_q == 9'd1) begin
`ifdef AWG_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = IDLE;
            fin_d   = 1'b1;
`endif
          end else begin
            state_d = SHI;
          end
        end
`ifdef AWG_LOADER_CHECKSUM_EN
        CHK: begin
          if (bus.in_byte == sum_q) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
`ifdef AWG_LOADER_CHECKSUM_EN
      if (state_q != IDLE && state_q != CHK) begin
        sum_d = sum_q + bus.in_byte;
      end
`endif
    end
  end

  // State and output registers; synchronous reset abandons any frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 8'h00;
      hi_q       <= 8'h00;
      remain_q   <= 9'd0;
      sel_q      <= 1'b0;
      timer_q    <= '0;
      awg_in_q   <= '0;
      awg_addr_q <= 8'h00;
      awg_sel_q  <= 1'b0;
      awg_ld_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef AWG_LOADER_CHECKSUM_EN
      sum_q      <= 8'h00;
`else
      fin_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      remain_q   <= remain_d;
      sel_q      <= sel_d;
      timer_q    <= timer_d;
      awg_in_q   <= awg_in_d;
      awg_addr_q <= awg_addr_d;
      awg_sel_q  <= awg_sel_d;
      awg_ld_q   <= awg_ld_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef AWG_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`else
      fin_q      <= fin_d;
`endif
    end
  end

endmodule

// File: tb/tb_awg_frame_loader.sv
// tb_awg_frame_loader: scoreboard bench for awg_frame_loader. Stimulus pushes
// bytes into a modelled rx queue and expected writes/events into scoreboard
// queues; a negedge monitor pops and compares whenever the DUT strobes.
module tb_awg_frame_loader;
  localparam int NBITS   = 12;
  localparam int TIMEOUT = 50;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct packed {
    logic             sel;
    logic [7:0]       addr;
    logic [NBITS-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  awg_frame_loader_if #(.NBITS(NBITS)) bus ();

  awg_frame_loader #(
    .NBITS  (NBITS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0]  rxQ[$];
  logic [15:0] pairQ[$];
  wr_t         expWrQ[$];
  int          expEvtQ[$];
  wr_t         monE;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rxQ.push_back(b);
  endtask

  task automatic expectWrite(input logic sel, input logic [7:0] addr, input logic [NBITS-1:0] data);
    wr_t w;
    w.sel  = sel;
    w.addr = addr;
    w.data = data;
    expWrQ.push_back(w);
  endtask

  task automatic sendFrame(input logic [7:0] ctrl, input logic [7:0] start, input logic [7:0] count,
                           input logic [7:0] chk, input int evt);
    logic [15:0] p;
    applyStimulus(8'hA5);
    applyStimulus(ctrl);
    applyStimulus(start);
    applyStimulus(count);
    while (pairQ.size() > 0) begin
      p = pairQ.pop_front();
      applyStimulus(p[15:8]);
      applyStimulus(p[7:0]);
    end
`ifdef AWG_LOADER_CHECKSUM_EN
    applyStimulus(chk);
`else
    if (chk === 8'hxx) $display("[TB] checksum byte not sent");
`endif
    expEvtQ.push_back(evt);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while ((rxQ.size() != 0 || expWrQ.size() != 0 || expEvtQ.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard not drained after %0d cycles (rx %0d wr %0d evt %0d)",
               name, budget, rxQ.size(), expWrQ.size(), expEvtQ.size());
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic waitRxEmpty(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (rxQ.size() != 0 && n < 200);
    if (rxQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: rx queue never drained", name);
    end
  endtask

  // Rx queue model: pop on each accepted byte, then present the new head.
  initial begin
    bus.em      = 1'b1;
    bus.in_byte = 8'h00;
    forever begin
      @(posedge clk);
      if (bus.pp && !bus.em && rxQ.size() > 0) void'(rxQ.pop_front());
      #1;
      if (rxQ.size() > 0) begin
        bus.em      = 1'b0;
        bus.in_byte = rxQ[0];
      end else begin
        bus.em      = 1'b1;
        bus.in_byte = 8'h00;
      end
    end
  end

  // Monitor: compare every write strobe and done/err pulse with the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.awg_ld) begin
        if (expWrQ.size() == 0) begin
          checkOutput("ld_unexpected", bus.awg_ld, 0);
        end else begin
          monE = expWrQ.pop_front();
          checkOutput("wr_sel", bus.awg_sel, monE.sel);
          checkOutput("wr_addr", bus.awg_addr, monE.addr);
          checkOutput("wr_data", bus.awg_in, monE.data);
        end
      end
      if (bus.done || bus.err) begin
        if (expEvtQ.size() == 0) begin
          checkOutput("evt_unexpected", {bus.err, bus.done}, 0);
        end else begin
          checkOutput("evt", {bus.err, bus.done}, expEvtQ.pop_front());
        end
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed frames with hand-computed writes, checksums and events.
  initial begin
    rst = 1'b1;
    applyStimulus(8'h00);
    repeat (3) @(negedge clk);
    checkOutput("rst_pp", bus.pp, 0);
    checkOutput("rst_ld", bus.awg_ld, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_sel", bus.awg_sel, 0);
    checkOutput("rst_addr", bus.awg_addr, 0);
    checkOutput("rst_in", bus.awg_in, 0);
    rst = 1'b0;

    $display("[TB] good frame");
    pairQ.push_back(16'h0123);
    pairQ.push_back(16'h0FFF);
    expectWrite(1'b0, 8'h10, 12'h123);
    expectWrite(1'b0, 8'h11, 12'hFFF);
    sendFrame(8'h00, 8'h10, 8'h02, 8'h44, EV_DONE);
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy_after_sync", bus.busy, 1);
    waitIdle("good_frame", 200);

    $display("[TB] garbage then wrap on channel 1");
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h5A);
    pairQ.push_back(16'h0001);
    pairQ.push_back(16'h0002);
    expectWrite(1'b1, 8'hFF, 12'h001);
    expectWrite(1'b1, 8'h00, 12'h002);
    sendFrame(8'h01, 8'hFF, 8'h02, 8'h05, EV_DONE);
    waitIdle("wrap_frame", 200);

`ifdef AWG_LOADER_CHECKSUM_EN
    $display("[TB] bad checksum");
    pairQ.push_back(16'h0123);
    pairQ.push_back(16'h0FFF);
    expectWrite(1'b0, 8'h10, 12'h123);
    expectWrite(1'b0, 8'h11, 12'hFFF);
    sendFrame(8'h00, 8'h10, 8'h02, 8'h45, EV_ERR);
    waitIdle("bad_chk", 200);
`endif

    $display("[TB] unused HI bits and CTRL bits ignored");
    pairQ.push_back(16'hF345);
    expectWrite(1'b0, 8'h20, 12'h345);
    sendFrame(8'hFE, 8'h20, 8'h01, 8'h57, EV_DONE);
    waitIdle("hi_mask", 200);

    $display("[TB] COUNT=0 gives 256 writes");
    for (int i = 0; i < 256; i++) begin
      pairQ.push_back({8'(i), ~8'(i)});
      expectWrite(1'b1, 8'(8'h80 + i), {4'(i), ~8'(i)});
    end
    sendFrame(8'h01, 8'h80, 8'h00, 8'h81, EV_DONE);
    waitIdle("count256", 2000);

    $display("[TB] stall 49 cycles after HI");
    expectWrite(1'b0, 8'h30, 12'h234);
    expEvtQ.push_back(EV_DONE);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h30);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    waitRxEmpty("stall49");
    repeat (48) @(posedge clk);
    @(negedge clk);
    checkOutput("stall49_busy", bus.busy, 1);
    @(posedge clk);
    applyStimulus(8'h34);
`ifdef AWG_LOADER_CHECKSUM_EN
    applyStimulus(8'h67);
`endif
    waitIdle("stall49", 200);

    $display("[TB] stall 50 cycles after HI");
    expEvtQ.push_back(EV_ERR);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h40);
    applyStimulus(8'h01);
    applyStimulus(8'h05);
    waitRxEmpty("stall50");
    repeat (49) @(posedge clk);
    @(negedge clk);
    checkOutput("stall50_busy_before", bus.busy, 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("stall50_busy_after", bus.busy, 0);
    applyStimulus(8'h42);
`ifdef AWG_LOADER_CHECKSUM_EN
    applyStimulus(8'h88);
`endif
    waitIdle("stall50", 200);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h50);
    applyStimulus(8'h02);
    applyStimulus(8'h07);
    waitRxEmpty("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_reset_busy", bus.busy, 0);
    checkOutput("mid_reset_ld", bus.awg_ld, 0);
    repeat (5) @(negedge clk);

    $display("[TB] frame after reset");
    pairQ.push_back(16'h0123);
    pairQ.push_back(16'h0FFF);
    expectWrite(1'b0, 8'h10, 12'h123);
    expectWrite(1'b0, 8'h11, 12'hFFF);
    sendFrame(8'h00, 8'h10, 8'h02, 8'h44, EV_DONE);
    waitIdle("after_reset", 200);

    repeat (5) @(negedge clk);
    checkOutput("end_wr_q", expWrQ.size(), 0);
    checkOutput("end_evt_q", expEvtQ.size(), 0);
    checkOutput("end_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/awg_frame_loader.md
# awg_frame_loader

- Parses host command frames arriving over the UART receive path and turns them into sample writes for the AWG waveform memories (`in`/`ld`/`addr`/`sel` inputs).
- Sits between the rx byte queue (pop-style interface: `out`/`em`/`pp`) and the two AWG instances.
- Lets the host download arbitrary waveforms without going through the control block.

## Interface
Parameters:
- `NBITS`, default 12: AWG sample width. Must be ≤ 16.
- `TIMEOUT`, default 100000: number of `clk` cycles allowed between consecutive bytes inside a frame before the frame is aborted.

Ports:
- `clk` (input, 1): system clock. One clock domain. Reset is synchronous and active-high.
- `rst` (input, 1): synchronous reset, active-high.
- `in_byte` (input, 8): head byte of the rx queue.
- `em` (input, 1): rx queue empty.
- `pp` (output, 1): pop the rx queue.
- `awg_in` (output, NBITS): sample data to write.
- `awg_addr` (output, 8): waveform memory address.
- `awg_sel` (output, 1): target channel (0 = dac0, 1 = dac1).
- `awg_ld` (output, 1): one-cycle write strobe.
- `busy` (output, 1): high while a frame is in progress (any state other than IDLE).
- `done` (output, 1): one-cycle pulse when a frame completes without error.
- `err` (output, 1): one-cycle pulse on checksum mismatch or timeout.

## Operation
Frame format, in byte order:
- SYNC = 0xA5
- CTRL: bit0 gives `awg_sel`; bits 7:1 are ignored.
- START: start address.
- COUNT: number of samples N; 0 means 256.
- N × (HI, LO): sample = {HI[NBITS-9:0], LO}; unused HI bits are ignored.
- CHK.

States: IDLE → CTRL → START → COUNT → SHI → SLO → (SHI | CHK) → IDLE.
- IDLE: pops every byte. Any byte other than 0xA5 is discarded silently. 0xA5 moves to CTRL.
- SLO: after the LO byte, issue a write at the current address, then increment the address modulo 256. After sample N go to CHK; otherwise go to SHI.
- Address wrap: START = 0xFF with N = 2 writes addresses 0xFF then 0x00.

Checksum:
- Running sum modulo 256 of every byte from CTRL through the last LO byte.
- In CHK, the byte is compared with the sum. Match: `done` pulses. Mismatch: `err` pulses.
- Writes already issued are not rolled back. The host re-sends the frame.

Byte consumption:
- A byte is consumed in any cycle with `pp`=1 and `em`=0.
- `pp` = !`em` && !`rst` (combinational), so the block can consume one byte per cycle.
- `in_byte` is sampled in the same cycle as the pop.

Timeout:
- A counter clears on every pop and counts while the state is not IDLE.
- When it reaches TIMEOUT, `err` pulses, the state returns to IDLE, and no further write is issued.

## Timing
- Reset values: `awg_ld`, `done`, `err`, `busy`, `awg_sel` = 0; `awg_addr` = 0; `awg_in` = 0; state = IDLE; checksum, counter and timeout are cleared.
- A LO byte popped in cycle t gives `awg_ld`=1 in cycle t+1, with `awg_addr`, `awg_in` and `awg_sel` valid in that same cycle.
- `awg_addr`, `awg_in` and `awg_sel` hold their values until the next write.
- A CHK byte popped in cycle t gives `done` or `err` in cycle t+1.
- `busy` goes high the cycle after SYNC is popped and low the cycle after CHK is popped or the timeout fires.
- A 0xA5 byte received in any state other than IDLE is treated as data, not as a resync.
- Reset during a frame returns to IDLE the next cycle. No `awg_ld`, `done` or `err` is emitted for the aborted frame.
- If the queue is empty for a cycle, the frame stalls with no state change, and the timeout counter advances.
- If a timeout occurs in the same cycle as a pop, the pop wins and the counter clears.

## Configuration
- `AWG_LOADER_CHECKSUM_EN` defined: the CHK byte is expected and checked as described above.
- Not defined: the frame ends after the last LO byte. `done` pulses in the cycle after the last write strobe. The CHK state and the checksum adder are removed, and `err` is produced only by timeout.

## Test plan
- Good frame: A5 00 10 02 | 01 23 | 0F FF | CHK=0x44 → writes (sel 0, addr 0x10, 0x123) then (addr 0x11, 0xFFF) on consecutive `awg_ld` pulses; `done` pulses once.
- Wrap and channel: A5 01 FF 02 with samples 0x001 and 0x002 and correct CHK → `awg_sel`=1 and writes to addr 0xFF then 0x00; `done` pulses.
- Bad checksum: the first frame with CHK = 0x45 → both writes still occur; `err` pulses; `done` stays 0.
- Garbage then resync: 00 FF 5A followed by a valid frame → the garbage bytes are popped with no writes, and the frame is processed normally. Separately, COUNT=00 → exactly 256 writes.
- Stall and timeout (TIMEOUT=50): stop after the HI byte for 49 cycles, then send LO → the write completes. Stopping for 50 cycles instead → `err` pulses, `busy` falls, and no write occurs. Asserting `rst` mid-frame → immediate IDLE with no pulses.
